// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode stage for the 16-bit pipeline.
//   - register bank (r0 reads as zero, writes to r0 ignored), combinational read
//   - immediate sign extension
//   - registered ID/EX boundary with valid/ready handshake, stall hold and flush
// Optional feature macro: ID_BYPASS_EN
//   defined   -> same-cycle write-through on bank reads, and held operands refresh
//                when a writeback hits their source index during a stall
//   undefined -> reads return the pre-write value, held operands never refresh
module id_stage_pipe #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 8,
  parameter int FUNCT_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic [IMM_W-1:0]      imm,
  input  logic [DATA_W-1:0]     pc4,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rs_data,
  output logic [DATA_W-1:0]     out_rt_data,
  output logic [DATA_W-1:0]     out_imm_ext,
  output logic [DATA_W-1:0]     out_pc4,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [FUNCT_W-1:0]    out_funct
);

  localparam int NREGS = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] R0 = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]     DZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0]     bank_r [NREGS];
  logic                  out_valid_r;
  logic [DATA_W-1:0]     rs_data_r;
  logic [DATA_W-1:0]     rt_data_r;
  logic [DATA_W-1:0]     imm_ext_r;
  logic [DATA_W-1:0]     pc4_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [FUNCT_W-1:0]    funct_r;

  logic [DATA_W-1:0]     rs_data_s;
  logic [DATA_W-1:0]     rt_data_s;
  logic [DATA_W-1:0]     imm_ext_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  wb_hit_s;

`ifdef ID_BYPASS_EN
  logic [REG_ADDR_W-1:0] rs_idx_r;
  logic [REG_ADDR_W-1:0] rt_idx_r;
`endif

  // A writeback that actually changes the bank (r0 is hardwired).
  assign wb_hit_s   = wb_we && (wb_addr != R0);
  // Ready does not look at in_valid so IF can rely on it without a loop.
  assign in_ready_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s && !flush;
  assign imm_ext_s  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  // Operand read: r0 forced to zero, optional same-cycle write-through.
  always_comb begin
    rs_data_s = DZERO;
    rt_data_s = DZERO;
    if (rs == R0) begin
      rs_data_s = DZERO;
`ifdef ID_BYPASS_EN
    end else if (wb_hit_s && (wb_addr == rs)) begin
      rs_data_s = wb_data;
`endif
    end else begin
      rs_data_s = bank_r[rs];
    end
    if (rt == R0) begin
      rt_data_s = DZERO;
`ifdef ID_BYPASS_EN
    end else if (wb_hit_s && (wb_addr == rt)) begin
      rt_data_s = wb_data;
`endif
    end else begin
      rt_data_s = bank_r[rt];
    end
  end

  // Register bank: cleared on reset, writes land regardless of flush/stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_r[i] <= DZERO;
      end
    end else if (wb_hit_s) begin
      bank_r[wb_addr] <= wb_data;
    end
  end

  // ID/EX boundary: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      rs_data_r   <= DZERO;
      rt_data_r   <= DZERO;
      imm_ext_r   <= DZERO;
      pc4_r       <= DZERO;
      rd_r        <= R0;
      funct_r     <= {FUNCT_W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      rs_data_r   <= rs_data_s;
      rt_data_r   <= rt_data_s;
      imm_ext_r   <= imm_ext_s;
      pc4_r       <= pc4;
      rd_r        <= rd;
      funct_r     <= funct;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
`ifdef ID_BYPASS_EN
    end else if (out_valid_r && wb_hit_s) begin
      // Stalled instruction picks up a value written to its source register.
      if (wb_addr == rs_idx_r) begin
        rs_data_r <= wb_data;
      end
      if (wb_addr == rt_idx_r) begin
        rt_data_r <= wb_data;
      end
`endif
    end
  end

`ifdef ID_BYPASS_EN
  // Source indices of the held instruction, kept for the stall-refresh compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs_idx_r <= R0;
      rt_idx_r <= R0;
    end else if (accept_s) begin
      rs_idx_r <= rs;
      rt_idx_r <= rt;
    end
  end
`endif

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_rs_data = rs_data_r;
  assign out_rt_data = rt_data_r;
  assign out_imm_ext = imm_ext_r;
  assign out_pc4     = pc4_r;
  assign out_rd      = rd_r;
  assign out_funct   = funct_r;

endmodule
